apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, gives the number of ACCESS cycles without pready before the transfer is aborted (legal range 1..255).
REQ-002 pclk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 preset  input  1  reset, synchronous and active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N has a transfer pending and holds it until reqN_done.
REQ-005 reqN_write  input  1  1 = write, 0 = read.
REQ-006 reqN_addr  input  9  bit 8 selects the slave (0 = slave1, 1 = slave2).
REQ-007 reqN_wdata  input  8  write data.
REQ-008 reqN_done  output  1  one-cycle pulse marking transfer completion.
REQ-009 reqN_rdata  output  8  read data, valid while reqN_done is high.
REQ-010 reqN_err  output  1  error flag, valid while reqN_done is high.
REQ-011 psel1, psel2, penable, pwrite  output  1 each  APB master control.
REQ-012 paddr  output  9;  pwdata  output  8  APB address and write data.
REQ-013 pready, pslverr  input  1 each;  prdata  input  8  APB slave response (already muxed).

Function
REQ-014 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-015 IDLE: psel1/psel2/penable = 0; if any eligible valid, pick a winner, latch write/addr/wdata, go to SETUP.
REQ-016 SETUP (exactly one cycle): psel1 = ~addr[8], psel2 = addr[8], penable = 0; go to ACCESS.
REQ-017 ACCESS: psel held, penable = 1; stay until pready = 1 or the timeout fires.
REQ-018 paddr/pwrite/pwdata SHALL come from the latched copy and stay stable through SETUP and ACCESS, whatever the requester inputs do.
REQ-019 On pready = 1 in ACCESS: next cycle the state is IDLE, psel/penable = 0, winner's done = 1, rdata = captured prdata (0 on writes), err = captured pslverr.
REQ-020 Minimum latency: valid sampled in cycle N gives SETUP at N+1, ACCESS at N+2 and done at N+3.
REQ-021 Arbitration SHALL be 2-way round-robin: on simultaneous valid, grant the requester not granted last; a sole valid requester is granted immediately.
REQ-022 While reqN_done is high, reqN_valid SHALL be ignored, so the same request is never reissued; the other requester may be granted in that same cycle (back-to-back).
REQ-023 Timeout: an 8-bit counter clears on entering ACCESS and increments each ACCESS cycle with pready = 0.
REQ-024 When the counter reaches TIMEOUT, the next cycle SHALL be IDLE with done = 1, err = 1, rdata = 0, and the APB selects dropped.
REQ-025 pready and timeout in the same cycle: pready wins (normal completion).
REQ-026 done/rdata/err SHALL be registered, and done/err SHALL be 0 for the non-winning requester.

Reset
REQ-027 While preset = 1 at a clock edge: state = IDLE and all outputs = 0 (psel*, penable, pwrite, paddr, pwdata, reqN_done, reqN_rdata, reqN_err).
REQ-028 Reset SHALL set the round-robin pointer so req0 wins the first tie, and SHALL clear the timeout counter.
REQ-029 Reset during SETUP/ACCESS aborts the transfer with no done pulse.

Structure
REQ-030 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the constants ADDR_W=9 and DATA_W=8.
REQ-031 Sub-module apb_rr_arbiter: 2-way round-robin grant with pointer update on grant; the FSM, latches and timeout stay in apb_arbiter.

Verification
REQ-032 req0 write 0x005/0xA5, pready tied 1: psel1 at N+1, penable at N+2, req0_done at N+3, err = 0, paddr = 0x005, pwdata = 0xA5.
REQ-033 req1 read 0x105, pready after 2 wait states with prdata = 0x3C: psel2 = 1, penable high 3 cycles, req1_done with rdata = 0x3C.
REQ-034 Both valid continuously from reset: grant order 0,1,0,1 with back-to-back transfers and no duplicated transfer.
REQ-035 TIMEOUT = 4, pready held 0: after 4 ACCESS cycles, done with err = 1, rdata = 0, selects dropped; pready = 1 in the 4th cycle gives normal completion.
REQ-036 pready = 1 with pslverr = 1 on a read: req0_err = 1 and rdata = prdata.
REQ-037 preset pulsed in ACCESS: next cycle all outputs 0 and no done; a pending request restarts from SETUP.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB arbiter slice.
package apb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant; the pointer remembers who was granted last.
module apb_rr_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (take_i && (req_i != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Reset points at req1 as last winner so req0 takes the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// access timeout and registered completion reporting per requester.
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              psel1,
    output logic              psel2,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    apb_state_e state_q, state_d;

    logic                   own_q, own_d;
    logic                   write_q, write_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [1:0]             done_q, done_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0] elig;
    logic [1:0] gnt;
    logic       tmo;

    // A requester whose done is showing is not eligible, so a held valid
    // is never taken as a second transfer.
    assign elig = {req1_valid & ~done_q[1], req0_valid & ~done_q[0]};
    assign tmo  = (state_q == ST_ACCESS) && !pready && (cnt_q == TO_LAST);

    apb_rr_arbiter u_rr (
        .clk_i  (pclk),
        .rst_i  (preset),
        .req_i  (elig),
        .take_i (state_q == ST_IDLE),
        .gnt_o  (gnt)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (elig != 2'b00) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || tmo) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        psel1   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        case (state_q)
            ST_SETUP: begin
                psel1 = ~addr_q[ADDR_W-1];
                psel2 = addr_q[ADDR_W-1];
            end
            ST_ACCESS: begin
                psel1   = ~addr_q[ADDR_W-1];
                psel2   = addr_q[ADDR_W-1];
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        own_d   = own_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        err_d   = '0;
        rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt[0]) begin
                    own_d   = 1'b0;
                    write_d = req0_write;
                    addr_d  = req0_addr;
                    wdata_d = req0_wdata;
                end else if (gnt[1]) begin
                    own_d   = 1'b1;
                    write_d = req1_write;
                    addr_d  = req1_addr;
                    wdata_d = req1_wdata;
                end
            end
            ST_SETUP: cnt_d = '0;
            ST_ACCESS: begin
                // pready takes priority over a timeout expiring in the same cycle.
                if (pready) begin
                    done_d[own_q]  = 1'b1;
                    err_d[own_q]   = pslverr;
                    rdata_d[own_q] = write_q ? '0 : prdata;
                end else if (tmo) begin
                    done_d[own_q] = 1'b1;
                    err_d[own_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            own_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            own_q   <= own_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign pwrite     = write_q;
    assign paddr      = addr_q;
    assign pwdata     = wdata_q;
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-age model.
module tb_apb_arbiter;

    localparam int TMO = 4;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [8:0] req0_addr = 0, req1_addr = 0;
    logic [7:0] req0_wdata = 0, req1_wdata = 0;
    logic       req0_done, req0_err, req1_done, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic       psel1, psel2, penable, pwrite;
    logic [8:0] paddr;
    logic [7:0] pwdata;
    logic       pready = 0, pslverr = 0;
    logic [7:0] prdata = 0;

    always #5 pclk = ~pclk;

    apb_arbiter #(.TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;
    bit rand_mode = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge pclk);
        @(negedge pclk);
    endtask

    // Model: m_age counts cycles since grant (0 = nothing in flight,
    // 1 = setup, 2.. = access cycle m_age-1).
    int         m_age = 0, m_own = 0, m_last = 1;
    logic [8:0] m_addr = 0;
    logic       m_write = 0;
    logic [7:0] m_wdata = 0;
    logic [1:0] e_done = 0, e_err = 0;
    logic [7:0] e_rd [2] = '{8'h0, 8'h0};

    initial forever begin : model
        logic [1:0] el;
        int g;
        @(posedge pclk);
        if (preset) begin
            m_age = 0; m_last = 1; m_addr = 0; m_write = 0; m_wdata = 0;
            e_done = 0; e_err = 0; e_rd[0] = 0; e_rd[1] = 0;
        end else begin
            el = {req1_valid & ~e_done[1], req0_valid & ~e_done[0]};
            e_done = 0; e_err = 0; e_rd[0] = 0; e_rd[1] = 0;
            if (m_age == 0) begin
                if (el != 0) begin
                    g = (el == 2'b11) ? 1 - m_last : (el[1] ? 1 : 0);
                    m_own = g; m_last = g; m_age = 1;
                    m_addr  = g ? req1_addr  : req0_addr;
                    m_write = g ? req1_write : req0_write;
                    m_wdata = g ? req1_wdata : req0_wdata;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (pready) begin
                e_done[m_own] = 1; e_err[m_own] = pslverr;
                e_rd[m_own] = m_write ? 8'h0 : prdata;
                m_age = 0;
            end else if (m_age - 1 == TMO) begin
                e_done[m_own] = 1; e_err[m_own] = 1;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    initial forever begin : compare
        @(negedge pclk);
        if (chk_en) begin
            chk("m_psel1",   psel1,   (m_age >= 1) && !m_addr[8]);
            chk("m_psel2",   psel2,   (m_age >= 1) && m_addr[8]);
            chk("m_penable", penable, m_age >= 2);
            chk("m_paddr",   paddr,   m_addr);
            chk("m_pwrite",  pwrite,  m_write);
            chk("m_pwdata",  pwdata,  m_wdata);
            chk("m_done0",   req0_done, e_done[0]);
            chk("m_done1",   req1_done, e_done[1]);
            chk("m_err0",    req0_err,  e_err[0]);
            chk("m_err1",    req1_err,  e_err[1]);
            chk("m_rdata0",  req0_rdata, e_rd[0]);
            chk("m_rdata1",  req1_rdata, e_rd[1]);
        end
    end

    task automatic rnd_req(input int n, input bit v);
        if (n == 0) begin
            req0_valid = v;
            if (v) begin req0_write = 1'($urandom); req0_addr = 9'($urandom); req0_wdata = 8'($urandom); end
        end else begin
            req1_valid = v;
            if (v) begin req1_write = 1'($urandom); req1_addr = 9'($urandom); req1_wdata = 8'($urandom); end
        end
    endtask

    initial forever begin : rand_driver
        @(negedge pclk);
        if (rand_mode) begin
            preset = ($urandom_range(0, 399) == 0);
            for (int n = 0; n < 2; n++) begin
                logic cur_v;
                cur_v = (n == 0) ? req0_valid : req1_valid;
                if (cur_v && e_done[n]) rnd_req(n, 1'($urandom));
                else if (!cur_v && ($urandom_range(0, 3) == 0)) rnd_req(n, 1'b1);
            end
            pready  = ($urandom_range(0, 2) == 0);
            pslverr = ($urandom_range(0, 3) == 0);
            prdata  = 8'($urandom);
        end
    end

    initial begin
        int order [4];
        int k;
        @(posedge pclk);
        @(negedge pclk);
        chk_en = 1;
        chk("rst_psel1", psel1, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_done0", req0_done, 0);

        // Both requesters valid continuously from reset.
        preset = 0; pready = 1;
        req0_valid = 1; req0_write = 1; req0_addr = 9'h010; req0_wdata = 8'h11;
        req1_valid = 1; req1_write = 1; req1_addr = 9'h120; req1_wdata = 8'h22;
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 4) chk("b2b_psel2", psel2, 1);
            if (req0_done && k < 4) begin order[k] = 0; k++; req0_addr = req0_addr + 9'd1; end
            if (req1_done && k < 4) begin order[k] = 1; k++; req1_addr = req1_addr + 9'd1; end
        end
        chk("rr_count", 16'(k), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", 16'(order[i]), 16'(i % 2));
        preset = 1; req0_valid = 0; req1_valid = 0;
        step();
        preset = 0;

        // req0 write, zero wait states.
        req0_valid = 1; req0_write = 1; req0_addr = 9'h005; req0_wdata = 8'hA5; pready = 1;
        step();
        chk("w_psel1_n1", psel1, 1); chk("w_pen_n1", penable, 0);
        chk("w_paddr", paddr, 9'h005); chk("w_pwdata", pwdata, 8'hA5); chk("w_pwrite", pwrite, 1);
        step();
        chk("w_pen_n2", penable, 1);
        step();
        chk("w_done_n3", req0_done, 1); chk("w_err", req0_err, 0); chk("w_psel1_off", psel1, 0);
        req0_valid = 0;
        step();
        chk("w_done_once", req0_done, 0);

        // req1 read with two wait states.
        req1_valid = 1; req1_write = 0; req1_addr = 9'h105; pready = 0;
        step();
        chk("r_psel2", psel2, 1); chk("r_pen_setup", penable, 0);
        for (int a = 1; a <= 3; a++) begin
            step();
            chk("r_pen_access", penable, 1);
            if (a == 3) begin pready = 1; prdata = 8'h3C; end
        end
        step();
        chk("r_done1", req1_done, 1); chk("r_rdata1", req1_rdata, 8'h3C); chk("r_done0", req0_done, 0);
        req1_valid = 0; pready = 0;
        step();

        // Slave error on a read.
        req0_valid = 1; req0_write = 0; req0_addr = 9'h0F0; pready = 1; pslverr = 1; prdata = 8'h5A;
        step(); step(); step();
        chk("e_done0", req0_done, 1); chk("e_err0", req0_err, 1); chk("e_rdata0", req0_rdata, 8'h5A);
        req0_valid = 0; pslverr = 0; pready = 0;
        step();

        // Timeout with pready held low.
        req0_valid = 1; req0_write = 0; req0_addr = 9'h0AA; prdata = 8'hEE;
        step();
        for (int a = 1; a <= TMO; a++) begin
            step();
            chk("t_pen", penable, 1);
        end
        step();
        chk("t_done", req0_done, 1); chk("t_err", req0_err, 1); chk("t_rdata", req0_rdata, 0);
        chk("t_psel1", psel1, 0); chk("t_pen_off", penable, 0);
        req0_valid = 0;
        step();

        // pready on the last access cycle wins over the timeout.
        req1_valid = 1; req1_write = 0; req1_addr = 9'h1AA;
        step();
        for (int a = 1; a <= TMO; a++) begin
            step();
            if (a == TMO) begin pready = 1; prdata = 8'h77; end
        end
        step();
        chk("tp_done", req1_done, 1); chk("tp_err", req1_err, 0); chk("tp_rdata", req1_rdata, 8'h77);
        req1_valid = 0; pready = 0;
        step();

        // Reset in the middle of an access.
        req0_valid = 1; req0_write = 1; req0_addr = 9'h033; req0_wdata = 8'h44;
        step(); step(); step();
        preset = 1;
        step();
        chk("ra_psel1", psel1, 0); chk("ra_pen", penable, 0); chk("ra_paddr", paddr, 0);
        chk("ra_pwdata", pwdata, 0); chk("ra_pwrite", pwrite, 0); chk("ra_done", req0_done, 0);
        preset = 0;
        step();
        chk("ra_restart_psel1", psel1, 1); chk("ra_restart_pen", penable, 0);
        chk("ra_restart_paddr", paddr, 9'h033);
        pready = 1;
        step(); step();
        chk("ra_done_after", req0_done, 1);
        req0_valid = 0; pready = 0;
        step();

        rand_mode = 1;
        repeat (4000) step();
        rand_mode = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
